mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 200 ++++++++++++++++++++
 tb/tb_mc_controller.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multi-cycle CPU control unit: Moore FSM sequencing fetch, decode and execute
// for 3-byte memory-reference and 1-byte register instructions.
module mc_controller #(
  parameter logic [1:0] ALU_ADD = 2'b00,
  parameter logic [1:0] ALU_SUB = 2'b01,
  parameter logic [1:0] ALU_AND = 2'b10,
  parameter logic [1:0] ALU_NOT = 2'b11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] OpCode,
  output logic       Halt,
  output logic       PCWrite,
  output logic       Jmp,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IOD,
  output logic       LdDI,
  output logic       LIR,
  output logic       LTR,
  output logic       RegSel,
  output logic       BSel,
  output logic       RegWrite,
  output logic       PcSel,
  output logic       LdC,
  output logic       LdN,
  output logic       LdZ,
  output logic       WriteSel,
  output logic [1:0] AluOp,
  output logic [1:0] RegOrMem,
  output logic       Halted
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH0  = 4'd1,
    DECODE  = 4'd2,
    FETCH1  = 4'd3,
    FETCH2  = 4'd4,
    MEM_LD  = 4'd5,
    MEM_ST  = 4'd6,
    MEM_ADD = 4'd7,
    WB_MEM  = 4'd8,
    JMP     = 4'd9,
    REG_MOV = 4'd10,
    REG_ALU = 4'd11,
    REG_WB  = 4'd12,
    HALT    = 4'd13
  } stateT;

  stateT      stateReg;
  stateT      stateNext;
  logic [3:0] opReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= IDLE;
      opReg    <= '0;
    end else begin
      stateReg <= stateNext;
      if (stateReg == DECODE) begin
        opReg <= OpCode;
      end
    end
  end

  // DECODE branches on the live OpCode; every later state uses only opReg.
  always_comb begin
    stateNext = IDLE;
    case (stateReg)
      IDLE:    stateNext = FETCH0;
      FETCH0:  stateNext = DECODE;
      DECODE: begin
        if (!OpCode[3]) begin
          stateNext = FETCH1;
        end else begin
          case (OpCode[2:0])
            3'b000:                         stateNext = REG_MOV;
            3'b001, 3'b010, 3'b011, 3'b100: stateNext = REG_ALU;
            3'b111:                         stateNext = HALT;
            default:                        stateNext = FETCH0;
          endcase
        end
      end
      FETCH1:  stateNext = FETCH2;
      FETCH2: begin
        case (opReg[2:1])
          2'b00:   stateNext = MEM_LD;
          2'b01:   stateNext = MEM_ST;
          2'b10:   stateNext = MEM_ADD;
          default: stateNext = JMP;
        endcase
      end
      MEM_LD:  stateNext = FETCH0;
      MEM_ST:  stateNext = FETCH0;
      MEM_ADD: stateNext = WB_MEM;
      WB_MEM:  stateNext = FETCH0;
      JMP:     stateNext = FETCH0;
      REG_MOV: stateNext = FETCH0;
      REG_ALU: stateNext = REG_WB;
      REG_WB:  stateNext = FETCH0;
      HALT:    stateNext = HALT;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    Halt     = 1'b0;
    PCWrite  = 1'b0;
    Jmp      = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IOD      = 1'b0;
    LdDI     = 1'b0;
    LIR      = 1'b0;
    LTR      = 1'b0;
    RegSel   = 1'b0;
    BSel     = 1'b0;
    RegWrite = 1'b0;
    PcSel    = 1'b0;
    LdC      = 1'b0;
    LdN      = 1'b0;
    LdZ      = 1'b0;
    WriteSel = 1'b0;
    AluOp    = ALU_ADD;
    RegOrMem = 2'b00;
    Halted   = 1'b0;
    case (stateReg)
      FETCH0, FETCH1: begin
        MemRead = 1'b1;
        LIR     = 1'b1;
        PCWrite = 1'b1;
      end
      DECODE: begin
        LdDI   = 1'b1;
        RegSel = 1'b1;
      end
      FETCH2: begin
        MemRead = 1'b1;
        LTR     = 1'b1;
        PCWrite = 1'b1;
      end
      MEM_LD: begin
        IOD      = 1'b1;
        MemRead  = 1'b1;
        RegWrite = 1'b1;
      end
      MEM_ST: begin
        IOD      = 1'b1;
        MemWrite = 1'b1;
      end
      MEM_ADD: begin
        IOD     = 1'b1;
        MemRead = 1'b1;
        BSel    = 1'b1;
        AluOp   = ALU_ADD;
        LdC     = 1'b1;
        LdZ     = 1'b1;
        LdN     = 1'b1;
      end
      WB_MEM: begin
        RegWrite = 1'b1;
        RegOrMem = 2'b01;
      end
      JMP: begin
        Jmp   = 1'b1;
        PcSel = 1'b1;
      end
      REG_MOV: begin
        RegWrite = 1'b1;
        RegOrMem = 2'b10;
        WriteSel = 1'b1;
      end
      REG_ALU: begin
        RegSel = 1'b1;
        LdZ    = 1'b1;
        LdN    = 1'b1;
        // Logical ops leave the carry flag untouched.
        case (opReg)
          4'b1001: begin AluOp = ALU_ADD; LdC = 1'b1; end
          4'b1010: begin AluOp = ALU_SUB; LdC = 1'b1; end
          4'b1011: AluOp = ALU_AND;
          4'b1100: AluOp = ALU_NOT;
          default: AluOp = ALU_ADD;
        endcase
      end
      REG_WB: begin
        RegWrite = 1'b1;
        RegOrMem = 2'b01;
        WriteSel = 1'b1;
      end
      HALT: begin
        Halt   = 1'b1;
        Halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Randomized instruction-stream bench for mc_controller: each instruction's
// per-cycle output vector is predicted from the instruction-set rules.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] OpCode = 4'b0000;
  logic Halt, PCWrite, Jmp, MemRead, MemWrite, IOD, LdDI, LIR, LTR, RegSel;
  logic BSel, RegWrite, PcSel, LdC, LdN, LdZ, WriteSel, Halted;
  logic [1:0] AluOp, RegOrMem;

  mc_controller dut (
    .clk(clk), .rst(rst), .OpCode(OpCode),
    .Halt(Halt), .PCWrite(PCWrite), .Jmp(Jmp), .MemRead(MemRead),
    .MemWrite(MemWrite), .IOD(IOD), .LdDI(LdDI), .LIR(LIR), .LTR(LTR),
    .RegSel(RegSel), .BSel(BSel), .RegWrite(RegWrite), .PcSel(PcSel),
    .LdC(LdC), .LdN(LdN), .LdZ(LdZ), .WriteSel(WriteSel),
    .AluOp(AluOp), .RegOrMem(RegOrMem), .Halted(Halted)
  );

  always #5 clk = ~clk;

  logic [21:0] obs;
  assign obs = {Halt, PCWrite, Jmp, MemRead, MemWrite, IOD, LdDI, LIR, LTR,
                RegSel, BSel, RegWrite, PcSel, LdC, LdN, LdZ, WriteSel,
                AluOp, RegOrMem, Halted};

  localparam logic [21:0] M_HALT   = 22'h200000;
  localparam logic [21:0] M_PCW    = 22'h100000;
  localparam logic [21:0] M_JMP    = 22'h080000;
  localparam logic [21:0] M_MRD    = 22'h040000;
  localparam logic [21:0] M_MWR    = 22'h020000;
  localparam logic [21:0] M_IOD    = 22'h010000;
  localparam logic [21:0] M_LDDI   = 22'h008000;
  localparam logic [21:0] M_LIR    = 22'h004000;
  localparam logic [21:0] M_LTR    = 22'h002000;
  localparam logic [21:0] M_RSEL   = 22'h001000;
  localparam logic [21:0] M_BSEL   = 22'h000800;
  localparam logic [21:0] M_RWR    = 22'h000400;
  localparam logic [21:0] M_PCSEL  = 22'h000200;
  localparam logic [21:0] M_LDC    = 22'h000100;
  localparam logic [21:0] M_LDN    = 22'h000080;
  localparam logic [21:0] M_LDZ    = 22'h000040;
  localparam logic [21:0] M_WSEL   = 22'h000020;
  localparam logic [21:0] M_HALTED = 22'h000001;

  int errors = 0;
  int checks = 0;
  logic [21:0] expSeq [0:31];
  int expLen;

  function automatic logic [21:0] aluF(input logic [1:0] a);
    return {17'b0, a, 3'b0};
  endfunction

  function automatic logic [21:0] romF(input logic [1:0] r);
    return {19'b0, r, 1'b0};
  endfunction

  task automatic checkEq(input string tag, input logic [21:0] got, input logic [21:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Expected output vector for every cycle from FETCH0 entry to the next FETCH0.
  task automatic buildExp(input logic [3:0] op);
    logic [1:0] code;
    int n;
    expSeq[0] = M_MRD | M_LIR | M_PCW;
    expSeq[1] = M_LDDI | M_RSEL;
    n = 2;
    if (!op[3]) begin
      expSeq[2] = M_MRD | M_LIR | M_PCW;
      expSeq[3] = M_MRD | M_LTR | M_PCW;
      n = 4;
      case (op[2:1])
        2'b00: begin expSeq[n] = M_IOD | M_MRD | M_RWR | romF(2'b00); n++; end
        2'b01: begin expSeq[n] = M_IOD | M_MWR; n++; end
        2'b10: begin
          expSeq[n] = M_IOD | M_MRD | M_BSEL | aluF(2'b00) | M_LDC | M_LDZ | M_LDN; n++;
          expSeq[n] = M_RWR | romF(2'b01); n++;
        end
        default: begin expSeq[n] = M_JMP | M_PCSEL; n++; end
      endcase
    end else if (op[2:0] == 3'b000) begin
      expSeq[n] = M_RWR | romF(2'b10) | M_WSEL; n++;
    end else if (op[2:0] >= 3'b001 && op[2:0] <= 3'b100) begin
      code = 2'(op[2:0] - 3'd1);  // ADD, SUB, AND, NOT in instruction order
      expSeq[n] = M_RSEL | aluF(code) | M_LDZ | M_LDN | ((code < 2'd2) ? M_LDC : 22'h0); n++;
      expSeq[n] = M_RWR | romF(2'b01) | M_WSEL; n++;
    end else if (op[2:0] == 3'b111) begin
      for (int k = 0; k < 20; k++) begin
        expSeq[n] = M_HALT | M_HALTED; n++;
      end
    end
    expLen = n;
  endtask

  // Called at a falling edge; returns at the falling edge inside the next FETCH0.
  task automatic doReset();
    #2 rst = 1'b1;
    #1 checkEq("rstAsync", obs, 22'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkEq("idleAfterRst", obs, 22'h0);
    @(negedge clk);
  endtask

  task automatic runInstr(input logic [3:0] op, input int abortAt,
                          input bit fixJunk, input logic [3:0] junkVal);
    int pcw;
    pcw = 0;
    buildExp(op);
    for (int i = 0; i < expLen; i++) begin
      checkEq($sformatf("op%b_cyc%0d", op, i), obs, expSeq[i]);
      if (obs[20]) pcw++;
      if (i == abortAt) begin
        doReset();
        $display("instr op=%b aborted by rst at cycle %0d", op, i);
        return;
      end
      if (i == 0) OpCode = op;
      else if (i >= 2) OpCode = fixJunk ? junkVal : 4'($urandom);
      @(negedge clk);
    end
    if (op == 4'b0010) checkEq("staPcWriteCount", 22'(pcw), 22'd3);
    if (op == 4'b1111) doReset();
    $display("instr op=%b cycles=%0d pcwrites=%0d", op, expLen, pcw);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] op;
    int ab;
    rst = 1'b1;
    #1 checkEq("rstInit", obs, 22'h0);
    repeat (3) begin
      @(negedge clk);
      checkEq("rstHold", obs, 22'h0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkEq("idleFirst", obs, 22'h0);
    @(negedge clk);

    runInstr(4'b1010, -1, 1'b0, 4'b0000);  // SUB
    runInstr(4'b0100, -1, 1'b1, 4'b1111);  // ADDM with HLT on the bus afterwards
    runInstr(4'b0010, -1, 1'b0, 4'b0000);  // STA
    runInstr(4'b0110, -1, 1'b0, 4'b0000);  // JMP
    runInstr(4'b0000, -1, 1'b0, 4'b0000);  // LDA
    runInstr(4'b1000, -1, 1'b0, 4'b0000);  // MOV
    runInstr(4'b1001, -1, 1'b1, 4'b1010);  // ADD
    runInstr(4'b1011, -1, 1'b0, 4'b0000);  // AND
    runInstr(4'b1100, -1, 1'b0, 4'b0000);  // NOT
    runInstr(4'b1101, -1, 1'b0, 4'b0000);  // NOP
    runInstr(4'b1110, -1, 1'b0, 4'b0000);  // NOP
    runInstr(4'b0100, 4, 1'b0, 4'b0000);   // ADDM cut off in MEM_ADD

    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 14));
      buildExp(op);
      ab = ($urandom_range(0, 5) == 0) ? $urandom_range(0, expLen - 1) : -1;
      runInstr(op, ab, 1'b0, 4'b0000);
    end

    runInstr(4'b1111, -1, 1'b0, 4'b0000);  // HLT held, then reset
    runInstr(4'b1001, -1, 1'b0, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
